// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard and trap sequencer: load-use stalls, branch flushes, memory waits, traps and mret.
// Optional stall watchdog enabled by defining STALL_TIMEOUT_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned STALL_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       cpurst_n,
    input  logic [4:0] id_rs1_index,
    input  logic [4:0] id_rs2_index,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       exe_is_load,
    input  logic [4:0] exe_rd_index,
    input  logic       exe_branch_taken,
    input  logic       mem_busy,
    input  logic       mem_exp,
    input  logic [3:0] mem_exp_cause,
    input  logic       irq_req,
    input  logic       irq_en,
    input  logic       mem_mret,
    output logic       if_hold,
    output logic       id_hold,
    output logic       exe_hold,
    output logic       id_flush,
    output logic       exe_bubble,
    output logic       mem_bubble,
    output logic       wb_bubble,
    output logic [1:0] pc_sel,
    output logic [4:0] trap_cause,
    output logic       trap_take,
    output logic       mem_abort
);

    typedef enum logic [1:0] {RUN, MEMWAIT, TRAP, MRET} state_t;

    state_t     state, state_nxt;
    logic       cause_load;
    logic [4:0] cause_nxt;
    logic       load_use;
    logic       irq_pend;
    logic       timeout_hit;

    if (STALL_TIMEOUT < 1) begin : g_bad_timeout
        $error("STALL_TIMEOUT must be at least 1");
    end

    assign load_use = exe_is_load && (exe_rd_index != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1_index == exe_rd_index)) ||
                       (id_uses_rs2 && (id_rs2_index == exe_rd_index)));
    assign irq_pend = irq_req & irq_en;

`ifdef STALL_TIMEOUT_EN
    localparam int CNT_W = (STALL_TIMEOUT > 255) ? $clog2(STALL_TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_TIMEOUT - 1);

    // Counts completed MEMWAIT cycles; the N-th wait cycle sees N-1.
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n)
            wait_cnt <= '0;
        else if (state == MEMWAIT)
            wait_cnt <= wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
    end

    assign timeout_hit = (state == MEMWAIT) && mem_busy && (wait_cnt == CNT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            state      <= RUN;
            trap_cause <= 5'd0;
        end else begin
            state <= state_nxt;
            if (cause_load)
                trap_cause <= cause_nxt;
        end
    end

    // NOTE: every output gets a default first so no latch is inferred on any path.
    always_comb begin
        state_nxt  = state;
        cause_load = 1'b0;
        cause_nxt  = 5'd0;
        if_hold    = 1'b0;
        id_hold    = 1'b0;
        exe_hold   = 1'b0;
        id_flush   = 1'b0;
        exe_bubble = 1'b0;
        mem_bubble = 1'b0;
        wb_bubble  = 1'b0;
        pc_sel     = 2'd0;
        trap_take  = 1'b0;
        mem_abort  = 1'b0;

        // Outputs are forced quiet for the whole time reset is held.
        if (cpurst_n) begin
            case (state)
                TRAP: begin
                    pc_sel    = 2'd2;
                    trap_take = 1'b1;
                    state_nxt = RUN;
                end
                MRET: begin
                    pc_sel    = 2'd3;
                    state_nxt = RUN;
                end
                default: begin
                    if (mem_exp || timeout_hit || ((state == RUN) && irq_pend && !mem_busy)) begin
                        id_flush   = 1'b1;
                        exe_bubble = 1'b1;
                        mem_bubble = 1'b1;
                        wb_bubble  = 1'b1;
                        cause_load = 1'b1;
                        state_nxt  = TRAP;
                        if (mem_exp) begin
                            cause_nxt = {1'b0, mem_exp_cause};
                        end else if (timeout_hit) begin
                            cause_nxt = 5'h05;
                            mem_abort = 1'b1;
                        end else begin
                            cause_nxt = 5'h1B;
                        end
                    end else if ((state == RUN) && mem_mret) begin
                        id_flush   = 1'b1;
                        exe_bubble = 1'b1;
                        mem_bubble = 1'b1;
                        state_nxt  = MRET;
                    end else if (mem_busy) begin
                        if_hold   = 1'b1;
                        id_hold   = 1'b1;
                        exe_hold  = 1'b1;
                        wb_bubble = 1'b1;
                        state_nxt = MEMWAIT;
                    end else begin
                        // Pipeline advances this cycle, so branch and load-use apply again.
                        state_nxt = RUN;
                        if (exe_branch_taken) begin
                            pc_sel     = 2'd1;
                            id_flush   = 1'b1;
                            exe_bubble = 1'b1;
                        end else if (load_use) begin
                            if_hold    = 1'b1;
                            id_hold    = 1'b1;
                            exe_bubble = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the hazard/trap rules.
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;
`ifdef STALL_TIMEOUT_EN
    localparam bit WATCHDOG = 1'b1;
`else
    localparam bit WATCHDOG = 1'b0;
`endif
    localparam logic [15:0] CAUSE_M = 16'h007C;

    logic       clk = 1'b0;
    logic       cpurst_n;
    logic [4:0] id_rs1_index, id_rs2_index, exe_rd_index;
    logic       id_uses_rs1, id_uses_rs2, exe_is_load, exe_branch_taken;
    logic       mem_busy, mem_exp, irq_req, irq_en, mem_mret;
    logic [3:0] mem_exp_cause;
    logic       if_hold, id_hold, exe_hold, id_flush, exe_bubble, mem_bubble, wb_bubble;
    logic [1:0] pc_sel;
    logic [4:0] trap_cause;
    logic       trap_take, mem_abort;
    logic [15:0] act_o;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.STALL_TIMEOUT(TO)) dut (
        .clk(clk), .cpurst_n(cpurst_n),
        .id_rs1_index(id_rs1_index), .id_rs2_index(id_rs2_index),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .exe_is_load(exe_is_load), .exe_rd_index(exe_rd_index),
        .exe_branch_taken(exe_branch_taken), .mem_busy(mem_busy),
        .mem_exp(mem_exp), .mem_exp_cause(mem_exp_cause),
        .irq_req(irq_req), .irq_en(irq_en), .mem_mret(mem_mret),
        .if_hold(if_hold), .id_hold(id_hold), .exe_hold(exe_hold),
        .id_flush(id_flush), .exe_bubble(exe_bubble), .mem_bubble(mem_bubble),
        .wb_bubble(wb_bubble), .pc_sel(pc_sel), .trap_cause(trap_cause),
        .trap_take(trap_take), .mem_abort(mem_abort)
    );

    assign act_o = {if_hold, id_hold, exe_hold, id_flush, exe_bubble, mem_bubble, wb_bubble,
                    pc_sel, trap_cause, trap_take, mem_abort};

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model state: where the sequencer is, the last trap cause, wait cycles so far.
    typedef enum int {M_RUN, M_WAIT, M_TRAP, M_MRET} mode_t;
    mode_t       m_mode = M_RUN;
    mode_t       n_mode = M_RUN;
    logic [4:0]  m_cause = 5'd0;
    logic [4:0]  n_cause = 5'd0;
    int          m_waits = 0;
    logic [15:0] exp_o;

    function automatic logic [15:0] ov(input logic ifh, idh, exh, idf, exb, meb, wbb,
                                       input logic [1:0] pc, input logic take, abt);
        return {ifh, idh, exh, idf, exb, meb, wbb, pc, 5'd0, take, abt};
    endfunction

    task automatic idle();
        id_rs1_index = 5'd0; id_rs2_index = 5'd0; exe_rd_index = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; exe_is_load = 1'b0;
        exe_branch_taken = 1'b0; mem_busy = 1'b0; mem_exp = 1'b0;
        mem_exp_cause = 4'd0; irq_req = 1'b0; irq_en = 1'b0; mem_mret = 1'b0;
    endtask

    // Let inputs settle, then predict this cycle's outputs and next state from the rules.
    task automatic settle();
        logic lu, timeout_now;
        #1;
        if (!cpurst_n) begin
            m_mode = M_RUN; m_cause = 5'd0; m_waits = 0;
        end
        lu = exe_is_load && exe_rd_index != 0 &&
             ((id_uses_rs1 && id_rs1_index == exe_rd_index) ||
              (id_uses_rs2 && id_rs2_index == exe_rd_index));
        timeout_now = WATCHDOG && m_mode == M_WAIT && mem_busy && (m_waits + 1 == TO);
        exp_o = 16'd0; n_mode = m_mode; n_cause = m_cause;
        if (cpurst_n) begin
            if (m_mode == M_TRAP) begin
                exp_o = ov(0,0,0,0,0,0,0,2'd2,1,0); n_mode = M_RUN;
            end else if (m_mode == M_MRET) begin
                exp_o = ov(0,0,0,0,0,0,0,2'd3,0,0); n_mode = M_RUN;
            end else if (mem_exp) begin
                exp_o = ov(0,0,0,1,1,1,1,2'd0,0,0); n_mode = M_TRAP;
                n_cause = {1'b0, mem_exp_cause};
            end else if (timeout_now) begin
                exp_o = ov(0,0,0,1,1,1,1,2'd0,0,1); n_mode = M_TRAP; n_cause = 5'h05;
            end else if (m_mode == M_RUN && irq_req && irq_en && !mem_busy) begin
                exp_o = ov(0,0,0,1,1,1,1,2'd0,0,0); n_mode = M_TRAP; n_cause = 5'h1B;
            end else if (m_mode == M_RUN && mem_mret) begin
                exp_o = ov(0,0,0,1,1,1,0,2'd0,0,0); n_mode = M_MRET;
            end else if (mem_busy) begin
                exp_o = ov(1,1,1,0,0,0,1,2'd0,0,0); n_mode = M_WAIT;
            end else begin
                n_mode = M_RUN;
                if (exe_branch_taken) exp_o = ov(0,0,0,1,1,0,0,2'd1,0,0);
                else if (lu)          exp_o = ov(1,1,0,0,1,0,0,2'd0,0,0);
            end
        end
        exp_o[6:2] = m_cause;
    endtask

    task automatic tick();
        @(posedge clk);
        if (cpurst_n) begin
            if (m_mode == M_WAIT) m_waits++; else m_waits = 0;
            m_mode = n_mode; m_cause = n_cause;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        cpurst_n = 1'b0; idle();
        mem_busy = 1'b1; exe_branch_taken = 1'b1; mem_exp = 1'b1; irq_req = 1'b1; irq_en = 1'b1;
        settle();
        n_vec++; if (act_o !== 16'd0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0000", act_o); end
        tick();
        cpurst_n = 1'b1; idle(); settle();
        n_vec++; if (act_o !== 16'd0) begin n_bad++; $display("FAIL reset_release: got %h want 0000", act_o); end
        tick();
    endtask

    task automatic test_load_use();
        logic [15:0] want;
        idle(); exe_is_load = 1'b1; exe_rd_index = 5'd5;
        id_uses_rs1 = 1'b1; id_rs1_index = 5'd3; id_uses_rs2 = 1'b1; id_rs2_index = 5'd5;
        settle(); want = ov(1,1,0,0,1,0,0,2'd0,0,0);
        n_vec++; if ((act_o & ~CAUSE_M) !== want) begin n_bad++; $display("FAIL load_use_stall: got %h want %h", act_o & ~CAUSE_M, want); end
        tick();
        idle(); settle();
        n_vec++; if ((act_o & ~CAUSE_M) !== 16'd0) begin n_bad++; $display("FAIL load_use_release: got %h want 0000", act_o & ~CAUSE_M); end
        tick();
        idle(); exe_is_load = 1'b1; exe_rd_index = 5'd0; id_uses_rs2 = 1'b1; id_rs2_index = 5'd0;
        settle();
        n_vec++; if ((act_o & ~CAUSE_M) !== 16'd0) begin n_bad++; $display("FAIL load_use_x0: got %h want 0000", act_o & ~CAUSE_M); end
        tick();
        idle(); exe_is_load = 1'b1; exe_rd_index = 5'd5; id_rs1_index = 5'd5; id_uses_rs1 = 1'b0;
        id_uses_rs2 = 1'b1; id_rs2_index = 5'd6;
        settle();
        n_vec++; if ((act_o & ~CAUSE_M) !== 16'd0) begin n_bad++; $display("FAIL load_use_unused_rs1: got %h want 0000", act_o & ~CAUSE_M); end
        tick();
    endtask

    task automatic test_mem_wait();
        logic [15:0] want;
        idle();
        for (int i = 0; i < 3; i++) begin
            mem_busy = 1'b1; exe_branch_taken = 1'b1;
            exe_is_load = 1'b1; exe_rd_index = 5'd7; id_uses_rs1 = 1'b1; id_rs1_index = 5'd7;
            settle(); want = ov(1,1,1,0,0,0,1,2'd0,0,0);
            n_vec++; if ((act_o & ~CAUSE_M) !== want) begin n_bad++; $display("FAIL mem_wait_hold[%0d]: got %h want %h", i, act_o & ~CAUSE_M, want); end
            tick();
        end
        mem_busy = 1'b0; settle(); want = ov(0,0,0,1,1,0,0,2'd1,0,0);
        n_vec++; if ((act_o & ~CAUSE_M) !== want) begin n_bad++; $display("FAIL mem_wait_branch_after: got %h want %h", act_o & ~CAUSE_M, want); end
        tick();
        idle(); irq_req = 1'b1; irq_en = 1'b1; settle(); want = ov(0,0,0,1,1,1,1,2'd0,0,0);
        n_vec++; if ((act_o & ~CAUSE_M) !== want) begin n_bad++; $display("FAIL mem_wait_back_in_run: got %h want %h", act_o & ~CAUSE_M, want); end
        tick();
        idle(); settle();
        n_vec++; if (act_o !== {ov(0,0,0,0,0,0,0,2'd2,1,0) | 16'h006C}) begin n_bad++; $display("FAIL mem_wait_irq_trap: got %h want %h", act_o, ov(0,0,0,0,0,0,0,2'd2,1,0) | 16'h006C); end
        tick();
    endtask

    task automatic test_mret();
        logic [15:0] want;
        idle(); mem_mret = 1'b1; settle(); want = ov(0,0,0,1,1,1,0,2'd0,0,0);
        n_vec++; if ((act_o & ~CAUSE_M) !== want) begin n_bad++; $display("FAIL mret_flush: got %h want %h", act_o & ~CAUSE_M, want); end
        tick();
        mem_mret = 1'b0; mem_busy = 1'b1; exe_branch_taken = 1'b1; mem_exp = 1'b1;
        settle(); want = ov(0,0,0,0,0,0,0,2'd3,0,0);
        n_vec++; if ((act_o & ~CAUSE_M) !== want) begin n_bad++; $display("FAIL mret_pc: got %h want %h", act_o & ~CAUSE_M, want); end
        tick();
        idle(); settle();
        n_vec++; if ((act_o & ~CAUSE_M) !== 16'd0) begin n_bad++; $display("FAIL mret_done: got %h want 0000", act_o & ~CAUSE_M); end
        tick();
    endtask

    task automatic test_exc_irq();
        logic [15:0] want;
        idle(); mem_exp = 1'b1; mem_exp_cause = 4'h7; irq_req = 1'b1; irq_en = 1'b1;
        settle(); want = ov(0,0,0,1,1,1,1,2'd0,0,0);
        n_vec++; if ((act_o & ~CAUSE_M) !== want) begin n_bad++; $display("FAIL exc_flush: got %h want %h", act_o & ~CAUSE_M, want); end
        tick();
        mem_exp = 1'b0; settle(); want = ov(0,0,0,0,0,0,0,2'd2,1,0);
        n_vec++; if ((act_o & ~CAUSE_M) !== want) begin n_bad++; $display("FAIL exc_trap: got %h want %h", act_o & ~CAUSE_M, want); end
        n_vec++; if (trap_cause !== 5'h07) begin n_bad++; $display("FAIL exc_cause: got %h want 07", trap_cause); end
        tick();
        settle(); want = ov(0,0,0,1,1,1,1,2'd0,0,0);
        n_vec++; if ((act_o & ~CAUSE_M) !== want) begin n_bad++; $display("FAIL irq_pending_flush: got %h want %h", act_o & ~CAUSE_M, want); end
        tick();
        irq_req = 1'b0; settle(); want = ov(0,0,0,0,0,0,0,2'd2,1,0);
        n_vec++; if ((act_o & ~CAUSE_M) !== want) begin n_bad++; $display("FAIL irq_trap: got %h want %h", act_o & ~CAUSE_M, want); end
        n_vec++; if (trap_cause !== 5'h1B) begin n_bad++; $display("FAIL irq_cause: got %h want 1b", trap_cause); end
        tick();
    endtask

    task automatic test_timeout();
        logic [15:0] want;
        idle();
`ifdef STALL_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            mem_busy = 1'b1; settle(); want = ov(1,1,1,0,0,0,1,2'd0,0,0);
            n_vec++; if ((act_o & ~CAUSE_M) !== want) begin n_bad++; $display("FAIL timeout_hold[%0d]: got %h want %h", i, act_o & ~CAUSE_M, want); end
            tick();
        end
        settle(); want = ov(0,0,0,1,1,1,1,2'd0,0,1);
        n_vec++; if ((act_o & ~CAUSE_M) !== want) begin n_bad++; $display("FAIL timeout_abort: got %h want %h", act_o & ~CAUSE_M, want); end
        tick();
        settle(); want = ov(0,0,0,0,0,0,0,2'd2,1,0);
        n_vec++; if ((act_o & ~CAUSE_M) !== want) begin n_bad++; $display("FAIL timeout_trap: got %h want %h", act_o & ~CAUSE_M, want); end
        n_vec++; if (trap_cause !== 5'h05) begin n_bad++; $display("FAIL timeout_cause: got %h want 05", trap_cause); end
        tick();
`else
        for (int i = 0; i < 1000; i++) begin
            mem_busy = 1'b1; settle(); want = ov(1,1,1,0,0,0,1,2'd0,0,0);
            n_vec++; if ((act_o & ~CAUSE_M) !== want) begin n_bad++; $display("FAIL no_timeout_hold[%0d]: got %h want %h", i, act_o & ~CAUSE_M, want); end
            tick();
        end
`endif
        idle(); settle();
        n_vec++; if ((act_o & ~CAUSE_M) !== 16'd0) begin n_bad++; $display("FAIL timeout_release: got %h want 0000", act_o & ~CAUSE_M); end
        tick();
    endtask

    task automatic test_reset_in_wait();
        idle();
        for (int i = 0; i < 2; i++) begin
            mem_busy = 1'b1; settle(); tick();
        end
        #2 cpurst_n = 1'b0;
        settle();
        n_vec++; if (act_o !== 16'd0) begin n_bad++; $display("FAIL rst_async_outputs: got %h want 0000", act_o); end
        tick();
        cpurst_n = 1'b1; mem_busy = 1'b0; settle();
        n_vec++; if (act_o !== 16'd0) begin n_bad++; $display("FAIL rst_release_run: got %h want 0000", act_o); end
        tick();
        settle();
        n_vec++; if (trap_take !== 1'b0 || mem_abort !== 1'b0) begin n_bad++; $display("FAIL rst_no_trap: got take=%b abort=%b want 0/0", trap_take, mem_abort); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cpurst_n         = ($urandom_range(0, 63) != 0);
            id_rs1_index     = 5'($urandom_range(0, 3));
            id_rs2_index     = 5'($urandom_range(0, 3));
            exe_rd_index     = 5'($urandom_range(0, 3));
            id_uses_rs1      = ($urandom_range(0, 3) != 0);
            id_uses_rs2      = ($urandom_range(0, 1) != 0);
            exe_is_load      = ($urandom_range(0, 1) != 0);
            exe_branch_taken = ($urandom_range(0, 3) == 0);
            mem_busy         = ($urandom_range(0, 2) == 0);
            mem_exp          = ($urandom_range(0, 15) == 0);
            mem_exp_cause    = 4'($urandom_range(0, 15));
            irq_req          = ($urandom_range(0, 5) == 0);
            irq_en           = ($urandom_range(0, 1) != 0);
            mem_mret         = ($urandom_range(0, 9) == 0);
            settle();
            n_vec++; if (act_o !== exp_o) begin n_bad++; $display("FAIL random[%0d]: got %h want %h", i, act_o, exp_o); end
            tick();
        end
        cpurst_n = 1'b1; idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_wait();
        test_mret();
        test_exc_irq();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
